// File: rtl/riscv_v_pipe_pkg.sv
// Shared types and helpers for the vector pipeline handshake stage.
package riscv_v_pipe_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_DEPTH   = 2;
    localparam int unsigned DEFAULT_STATS_W = 16;

    // Widest statistics counter supported; narrower counters use the low bits.
    localparam int unsigned STATS_W_MAX = 32;

    typedef logic [STATS_W_MAX-1:0] stats_t;

    // Increment that sticks at the all-ones value of a counter that is 'width' bits wide.
    function automatic stats_t stats_sat_inc(input stats_t value, input int unsigned width);
        stats_t max_v;
        if (width >= STATS_W_MAX) begin
            max_v = '1;
        end else begin
            max_v = (stats_t'(1) << width) - stats_t'(1);
        end
        return (value >= max_v) ? max_v : value + stats_t'(1);
    endfunction

endpackage

// File: rtl/riscv_v_pipe_slot.sv
// One valid+data slot of the handshake pipeline; loads from upstream when its advance is set.
module riscv_v_pipe_slot
    import riscv_v_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_rst_val,
    input  logic             i_flush,
    input  logic             i_adv,
    input  logic             i_up_valid,
    input  logic [WIDTH-1:0] i_up_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_adv) begin
            r_valid <= i_up_valid;
        end
    end

    // Data only moves with a real beat; bubbles and flushes leave the payload untouched.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data <= i_rst_val;
        end else if (i_adv && i_up_valid && !i_flush) begin
            r_data <= i_up_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/riscv_v_pipe_stage_hs.sv
// Multi-slot valid/ready pipeline register with bubble collapsing and synchronous flush.
// Define RISCV_V_PIPE_STATS_EN to build the saturating stall/flush counters.
module riscv_v_pipe_stage_hs
    import riscv_v_pipe_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned DEPTH   = DEFAULT_DEPTH,
    parameter int unsigned STATS_W = DEFAULT_STATS_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           rst_val,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [STATS_W-1:0]         stall_cnt,
    output logic [STATS_W-1:0]         flush_cnt
);

    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH-1:0] w_adv;
    logic [OCC_W-1:0] w_occ;

    // A slot advances when it is empty or the slot after it advances.
    always_comb begin : adv_chain
        logic v_acc;
        v_acc = out_ready;
        w_adv = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            v_acc    = v_acc | ~w_valid[i];
            w_adv[i] = v_acc;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;

        if (g == 0) begin : g_head
            assign w_up_valid = in_valid;
            assign w_up_data  = in_data;
        end else begin : g_body
            assign w_up_valid = w_valid[g-1];
            assign w_up_data  = w_data[g-1];
        end

        riscv_v_pipe_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_rst_val  (rst_val),
            .i_flush    (flush),
            .i_adv      (w_adv[g]),
            .i_up_valid (w_up_valid),
            .i_up_data  (w_up_data),
            .o_valid    (w_valid[g]),
            .o_data     (w_data[g])
        );
    end

    always_comb begin
        w_occ = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            w_occ = w_occ + OCC_W'(w_valid[i]);
        end
    end

    assign in_ready  = w_adv[0] & ~flush;
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];
    assign occupancy = w_occ;

`ifdef RISCV_V_PIPE_STATS_EN
    logic [STATS_W-1:0] r_stall_cnt;
    logic [STATS_W-1:0] r_flush_cnt;
    stats_t             w_stall_inc;
    stats_t             w_flush_inc;

    assign w_stall_inc = stats_sat_inc(stats_t'(r_stall_cnt), STATS_W);
    assign w_flush_inc = stats_sat_inc(stats_t'(r_flush_cnt), STATS_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready) begin
                r_stall_cnt <= w_stall_inc[STATS_W-1:0];
            end
            if (flush && (w_occ != '0)) begin
                r_flush_cnt <= w_flush_inc[STATS_W-1:0];
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_v_pipe_stage_hs.sv
// Bench for riscv_v_pipe_stage_hs: beat-position reference model plus directed literal checks.
module tb_riscv_v_pipe_stage_hs;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 3;
    localparam int STATS_W  = 4;
    localparam int STAT_MAX = 15;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] rst_val;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       occupancy;
    logic [STATS_W-1:0] stall_cnt;
    logic [STATS_W-1:0] flush_cnt;

    riscv_v_pipe_stage_hs #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .STATS_W (STATS_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rst_val   (rst_val),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: each buffered beat carries its slot position, oldest first.
    int               m_pos[$];
    logic [WIDTH-1:0] m_dat[$];
    int               m_np[$];
    logic [WIDTH-1:0] m_last;
    int               m_stall;
    int               m_flush;
    bit               m_acc;

`ifdef RISCV_V_PIPE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos.delete();
        m_dat.delete();
        m_last  = rst_val;
        m_stall = 0;
        m_flush = 0;
    endtask

    // Where each beat sits after this edge (-1 = leaves downstream), ignoring flush.
    task automatic calc_np();
        m_np.delete();
        for (int k = 0; k < m_pos.size(); k++) begin
            int tgt;
            if (k == 0) begin
                if (m_pos[0] == DEPTH - 1) tgt = out_ready ? -1 : DEPTH - 1;
                else tgt = m_pos[0] + 1;
            end else begin
                tgt = (m_np[k-1] == m_pos[k] + 1) ? m_pos[k] : m_pos[k] + 1;
            end
            m_np.push_back(tgt);
        end
    endtask

    function automatic bit m_in_ready();
        if (flush) return 1'b0;
        if (m_pos.size() == 0) return 1'b1;
        return m_np[m_np.size()-1] != 0;
    endfunction

    function automatic bit m_out_valid();
        return (m_pos.size() > 0) && (m_pos[0] == DEPTH - 1);
    endfunction

    task automatic compare();
        logic [WIDTH-1:0] exp_data;
        calc_np();
        exp_data = m_out_valid() ? m_dat[0] : m_last;
        chk("out_valid", 64'(out_valid), 64'(m_out_valid()));
        chk("out_data", 64'(out_data), 64'(exp_data));
        chk("occupancy", 64'(occupancy), 64'(m_pos.size()));
        chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
        chk("stall_cnt", 64'(stall_cnt), STATS_ON ? 64'(m_stall) : 64'd0);
        chk("flush_cnt", 64'(flush_cnt), STATS_ON ? 64'(m_flush) : 64'd0);
    endtask

    task automatic model_update();
        calc_np();
        m_acc = in_valid && m_in_ready();
        if (m_out_valid() && !out_ready && m_stall < STAT_MAX) m_stall++;
        if (flush && m_pos.size() > 0 && m_flush < STAT_MAX) m_flush++;
        if (flush) begin
            m_pos.delete();
            m_dat.delete();
        end else begin
            if (m_np.size() > 0 && m_np[0] == -1) begin
                void'(m_np.pop_front());
                void'(m_pos.pop_front());
                void'(m_dat.pop_front());
            end
            m_pos = m_np;
            if (m_acc) begin
                m_pos.push_back(0);
                m_dat.push_back(in_data);
            end
        end
        if (m_out_valid()) m_last = m_dat[0];
    endtask

    // Inputs must be set before calling; returns 1 time unit after the edge.
    task automatic step();
        @(negedge clk);
        compare();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic ordy);
        in_valid  = 1'b0;
        out_ready = ordy;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] bp [4];
        int idx;

        rst       = 1'b1;
        rst_val   = 32'hA5A5_A5A5;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'hA5A5_A5A5);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        model_reset();
        #9 rst = 1'b0;
        @(posedge clk);
        #1;

        // Streaming: first beat visible two edges after its acceptance edge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        step();
        chk("stream_lat0", 64'(out_valid), 64'd0);
        in_data = 32'h2;
        step();
        chk("stream_lat1", 64'(out_valid), 64'd0);
        in_data = 32'h3;
        step();
        chk("stream_first_valid", 64'(out_valid), 64'd1);
        chk("stream_first_data", 64'(out_data), 64'h1);
        for (int d = 4; d <= 8; d++) begin
            in_data = WIDTH'(d);
            step();
        end
        idle(4, 1'b1);

        // Backpressure: four beats offered, three fit while downstream stalls.
        bp[0] = 32'h100; bp[1] = 32'h101; bp[2] = 32'h102; bp[3] = 32'h103;
        idx = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_data  = bp[idx];
            step();
            if (m_acc) idx++;
        end
        chk("bp_occupancy", 64'(occupancy), 64'd3);
        chk("bp_in_ready_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_pass", 64'(in_ready), 64'd1);
        for (int c = 0; c < 8; c++) begin
            in_valid = (idx < 4);
            in_data  = bp[idx < 4 ? idx : 3];
            step();
            if (m_acc) idx++;
        end
        idle(2, 1'b1);

        // Bubble collapse: build slots 1,0,1 under stall, then accept one more.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h200;
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        in_data  = 32'h201;
        step();
        chk("bubble_occ2", 64'(occupancy), 64'd2);
        in_data = 32'h202;
        #1;
        chk("bubble_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("bubble_occ3", 64'(occupancy), 64'd3);
        chk("bubble_out_data", 64'(out_data), 64'h200);
        idle(4, 1'b1);

        // Flush with two beats buffered and a beat on the input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h300;
        step();
        in_data = 32'h301;
        step();
        chk("flush_pre_occ", 64'(occupancy), 64'd2);
        flush   = 1'b1;
        in_data = 32'hDEAD;
        #1;
        chk("flush_in_ready", 64'(in_ready), 64'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_data", 64'(out_data), 64'h202);
        chk("flush_cnt_lit", 64'(flush_cnt), STATS_ON ? 64'd1 : 64'd0);
        for (int c = 0; c < 4; c++) begin
            out_ready = 1'b1;
            step();
            chk("flush_no_emerge", 64'(out_valid), 64'd0);
        end

        // Stall counter saturation.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h400;
        step();
        idle(22, 1'b0);
        chk("stall_sat", 64'(stall_cnt), STATS_ON ? 64'd15 : 64'd0);
        idle(4, 1'b1);

        // Randomised traffic.
        for (int c = 0; c < 2000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_data   = $urandom;
            step();
        end
        flush = 1'b0;

        // Asynchronous reset mid-stream with a new reset value.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = $urandom;
            step();
        end
        in_valid = 1'b0;
        rst_val  = 32'h5A5A_0F0F;
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_occupancy", 64'(occupancy), 64'd0);
        chk("arst_out_data", 64'(out_data), 64'h5A5A_0F0F);
        chk("arst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("arst_flush_cnt", 64'(flush_cnt), 64'd0);
        model_reset();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 200; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
